// File: rtl/dist_pkg.sv
// dist_pkg: shared mode and buffer-state encodings for the distribution crossbar
package dist_pkg;
  typedef enum logic [1:0] {MODE_SEL = 2'b00, MODE_BCAST = 2'b01, MODE_IDENT = 2'b10} mode_e;
  typedef enum logic [1:0] {ST_EMPTY = 2'b00, ST_ONE = 2'b01, ST_TWO = 2'b10} state_e;
endpackage

// File: rtl/dist_lane_mux.sv
// dist_lane_mux: one output lane, element select with mask zeroing and out-of-range flag
module dist_lane_mux import dist_pkg::*; #(
  parameter int DATA_TYPE = 16,
  parameter int INPUT_BW  = 64,
  parameter int SEL_W     = 6,
  parameter int LANE      = 0
)(
  input  logic [INPUT_BW*DATA_TYPE-1:0] data_i,
  input  logic [SEL_W-1:0]              sel_i,
  input  logic [SEL_W-1:0]              sel0_i,
  input  logic [1:0]                    mode_i,
  input  logic                          en_i,
  output logic [DATA_TYPE-1:0]          data_o,
  output logic                          oor_o
);
  logic [31:0]          idx;
  logic [DATA_TYPE-1:0] elem;
  always_comb begin
    idx = mode_i == MODE_BCAST ? 32'(sel0_i) : mode_i == MODE_IDENT ? 32'(LANE % INPUT_BW) : 32'(sel_i);
    elem = '0;
    for (int k = 0; k < INPUT_BW; k++) if (idx == 32'(k)) elem = data_i[k*DATA_TYPE +: DATA_TYPE];
    oor_o = en_i && mode_i != MODE_IDENT && idx >= 32'(INPUT_BW);
    data_o = en_i ? elem : '0;
  end
endmodule

// File: rtl/dist_xbar_pipe.sv
// dist_xbar_pipe: routed distribution crossbar with two-entry skid buffer,
// sticky out-of-range flag and delivered-vector counter
module dist_xbar_pipe import dist_pkg::*; #(
  parameter int DATA_TYPE = 16,
  parameter int NUM_PES   = 64,
  parameter int INPUT_BW  = 64,
  parameter int SEL_W     = 6,
  parameter int CNT_W     = 32
)(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [INPUT_BW*DATA_TYPE-1:0] i_data_bus,
  input  logic [NUM_PES*SEL_W-1:0]      i_mux_bus,
  input  logic [1:0]                    i_mode,
  input  logic [NUM_PES-1:0]            i_pe_mask,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic [NUM_PES*DATA_TYPE-1:0]  o_dist_bus,
  output logic [NUM_PES-1:0]            o_pe_en,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_err,
  output logic [CNT_W-1:0]              o_xfer_cnt
);
  localparam int DW = NUM_PES*DATA_TYPE;
  logic [DW-1:0]      route, main_q, main_d, skid_q, skid_d;
  logic [NUM_PES-1:0] oor, main_en_q, main_en_d, skid_en_q, skid_en_d;
  state_e             state_q, state_d;
  logic               ready_q, err_q, err_d, accept, drain;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  for (genvar i = 0; i < NUM_PES; i++) begin : g_lane
    dist_lane_mux #(.DATA_TYPE(DATA_TYPE), .INPUT_BW(INPUT_BW), .SEL_W(SEL_W), .LANE(i)) u_lane (
      .data_i(i_data_bus),
      .sel_i (i_mux_bus[i*SEL_W +: SEL_W]),
      .sel0_i(i_mux_bus[SEL_W-1:0]),
      .mode_i(i_mode),
      .en_i  (i_pe_mask[i]),
      .data_o(route[i*DATA_TYPE +: DATA_TYPE]),
      .oor_o (oor[i])
    );
  end
  assign accept = i_valid && ready_q;
  assign drain  = o_valid && i_ready;
  // accept already implies the buffer is not full, so MAIN loads new data when empty or draining
  always_comb begin
    state_d = state_q == ST_EMPTY ? (accept ? ST_ONE : ST_EMPTY)
            : state_q == ST_ONE ? (accept && !drain ? ST_TWO : !accept && drain ? ST_EMPTY : ST_ONE)
            : drain ? ST_ONE : ST_TWO;
    main_d    = state_q == ST_TWO && drain ? skid_q : accept && (state_q == ST_EMPTY || drain) ? route : main_q;
    main_en_d = state_q == ST_TWO && drain ? skid_en_q : accept && (state_q == ST_EMPTY || drain) ? i_pe_mask : main_en_q;
    skid_d    = accept && state_q == ST_ONE && !drain ? route : skid_q;
    skid_en_d = accept && state_q == ST_ONE && !drain ? i_pe_mask : skid_en_q;
    err_d     = err_q || (accept && |oor);
    cnt_d     = cnt_q + CNT_W'(drain);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_EMPTY;
      ready_q   <= 1'b0;
      main_q    <= '0;
      main_en_q <= '0;
      skid_q    <= '0;
      skid_en_q <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= state_d != ST_TWO;
      main_q    <= main_d;
      main_en_q <= main_en_d;
      skid_q    <= skid_d;
      skid_en_q <= skid_en_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end
  assign o_ready    = ready_q;
  assign o_valid    = state_q != ST_EMPTY;
  assign o_dist_bus = main_q;
  assign o_pe_en    = main_en_q;
  assign o_err      = err_q;
  assign o_xfer_cnt = cnt_q;
endmodule

// File: tb/tb_dist_xbar_pipe.sv
// tb_dist_xbar_pipe: table vectors, hand sequences and a queue-based reference model
module tb_dist_xbar_pipe;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] i_data_bus = '0, o_dist_bus;
  logic [7:0]  i_mux_bus = '0, o_xfer_cnt;
  logic [1:0]  i_mode = '0;
  logic [3:0]  i_pe_mask = '0, o_pe_en;
  logic        i_valid = 1'b0, i_ready = 1'b1, o_ready, o_valid, o_err;

  logic [23:0] b_data = 24'h332211;
  logic [31:0] b_dist;
  logic [7:0]  b_mux = '0;
  logic [1:0]  b_mode = '0, b_cnt;
  logic [3:0]  b_mask = '0, b_en;
  logic        b_valid = 1'b0, b_iready = 1'b1, b_ready, b_ovalid, b_err;

  dist_xbar_pipe #(.DATA_TYPE(8), .NUM_PES(4), .INPUT_BW(4), .SEL_W(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .i_data_bus(i_data_bus), .i_mux_bus(i_mux_bus), .i_mode(i_mode),
    .i_pe_mask(i_pe_mask), .i_valid(i_valid), .o_ready(o_ready), .o_dist_bus(o_dist_bus),
    .o_pe_en(o_pe_en), .o_valid(o_valid), .i_ready(i_ready), .o_err(o_err), .o_xfer_cnt(o_xfer_cnt));

  dist_xbar_pipe #(.DATA_TYPE(8), .NUM_PES(4), .INPUT_BW(3), .SEL_W(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .i_data_bus(b_data), .i_mux_bus(b_mux), .i_mode(b_mode),
    .i_pe_mask(b_mask), .i_valid(b_valid), .o_ready(b_ready), .o_dist_bus(b_dist),
    .o_pe_en(b_en), .o_valid(b_ovalid), .i_ready(b_iready), .o_err(b_err), .o_xfer_cnt(b_cnt));

  typedef struct packed {logic [31:0] d; logic [3:0] en;} ent_t;
  typedef struct {logic [31:0] data; logic [7:0] mux; logic [1:0] mode; logic [3:0] mask; logic [31:0] exp_d; logic [3:0] exp_en;} vec_t;
  typedef struct {logic [7:0] mux; logic [1:0] mode; logic [3:0] mask; logic [31:0] exp_d; logic exp_err;} bvec_t;

  int n_cmp = 0, n_bad = 0;
  ent_t q[$];
  logic up = 1'b0, merr = 1'b0;
  logic [7:0] mcnt = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic ent_t route(input logic [31:0] d, input logic [7:0] m, input logic [1:0] md, input logic [3:0] mk);
    ent_t r;
    int s;
    for (int i = 0; i < 4; i++) begin
      s = md == 2'd1 ? int'(m[1:0]) : md == 2'd2 ? i : int'(m[2*i +: 2]);
      r.d[8*i +: 8] = mk[i] ? d[8*s +: 8] : 8'h00;
    end
    r.en = mk;
    return r;
  endfunction

  // one clock: advance the queue model at the edge, compare at the following negedge
  task automatic step();
    int pre;
    logic acc, drn;
    @(posedge clk);
    if (!rst) begin
      q.delete();
      up = 1'b0;
      merr = 1'b0;
      mcnt = '0;
    end else begin
      pre = q.size();
      acc = i_valid && up && pre < 2;
      drn = pre > 0 && i_ready;
      if (drn) begin
        void'(q.pop_front());
        mcnt++;
      end
      if (acc) q.push_back(route(i_data_bus, i_mux_bus, i_mode, i_pe_mask));
      up = 1'b1;
    end
    @(negedge clk);
    chk("model_ready", o_ready, up && q.size() < 2);
    chk("model_valid", o_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("model_dist", o_dist_bus, q[0].d);
      chk("model_en", o_pe_en, q[0].en);
    end
    chk("model_err", o_err, merr);
    chk("model_cnt", o_xfer_cnt, mcnt);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    i_valid = 1'b0;
    b_valid = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
  endtask

  vec_t  tbl[6];
  bvec_t btbl[5];
  ent_t  bp_vec[5];
  logic [31:0] bp_d[5];
  logic [7:0]  bp_m[5];
  logic [1:0]  bp_md[5];
  logic [3:0]  bp_mk[5];
  ent_t  got[$];

  initial begin
    tbl[0] = '{32'h40302010, 8'h1B, 2'd0, 4'hF, 32'h10203040, 4'hF};
    tbl[1] = '{32'h40302010, 8'h02, 2'd1, 4'h5, 32'h00300030, 4'h5};
    tbl[2] = '{32'h40302010, 8'hE4, 2'd2, 4'hF, 32'h40302010, 4'hF};
    tbl[3] = '{32'h40302010, 8'h1B, 2'd3, 4'hA, 32'h10003000, 4'hA};
    tbl[4] = '{32'h40302010, 8'h55, 2'd0, 4'h6, 32'h00202000, 4'h6};
    tbl[5] = '{32'hAABBCCDD, 8'hFF, 2'd1, 4'hF, 32'hAAAAAAAA, 4'hF};
    btbl[0] = '{8'h0C, 2'd0, 4'hD, 32'h11110011, 1'b0};
    btbl[1] = '{8'h0C, 2'd1, 4'hF, 32'h11111111, 1'b0};
    btbl[2] = '{8'h0C, 2'd0, 4'hF, 32'h11110011, 1'b1};
    btbl[3] = '{8'h24, 2'd0, 4'hF, 32'h11332211, 1'b1};
    btbl[4] = '{8'hFF, 2'd2, 4'hF, 32'h11332211, 1'b1};

    i_valid = 1'b1;
    i_data_bus = 32'h12345678;
    i_mux_bus = 8'h1B;
    i_pe_mask = 4'hF;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_ready", o_ready, 1'b0);
      chk("rst_dist", o_dist_bus, 32'h0);
      chk("rst_en", o_pe_en, 4'h0);
      chk("rst_err", o_err, 1'b0);
      chk("rst_cnt", o_xfer_cnt, 8'h0);
    end
    rst = 1'b1;
    step();
    chk("rel_ready", o_ready, 1'b1);
    chk("rel_valid", o_valid, 1'b0);

    for (int j = 0; j < 6; j++) begin
      {i_data_bus, i_mux_bus, i_mode, i_pe_mask} = {tbl[j].data, tbl[j].mux, tbl[j].mode, tbl[j].mask};
      i_valid = 1'b1;
      step();
      chk("tbl_valid", o_valid, 1'b1);
      chk("tbl_dist", o_dist_bus, tbl[j].exp_d);
      chk("tbl_en", o_pe_en, tbl[j].exp_en);
      chk("tbl_cnt", o_xfer_cnt, 8'(j));
    end
    i_valid = 1'b0;
    step();
    chk("tbl_cnt_end", o_xfer_cnt, 8'd6);

    do_reset();
    for (int k = 0; k < 5; k++) begin
      bp_d[k] = $urandom;
      bp_m[k] = 8'($urandom);
      bp_md[k] = 2'($urandom);
      bp_mk[k] = 4'($urandom);
      bp_vec[k] = route(bp_d[k], bp_m[k], bp_md[k], bp_mk[k]);
    end
    begin
      int k = 0;
      for (int c = 0; c < 20; c++) begin
        i_ready = (c >= 1 && c <= 5) ? 1'b0 : 1'b1;
        i_valid = k < 5;
        if (k < 5) {i_data_bus, i_mux_bus, i_mode, i_pe_mask} = {bp_d[k], bp_m[k], bp_md[k], bp_mk[k]};
        if (o_valid && i_ready) got.push_back('{o_dist_bus, o_pe_en});
        if (i_valid && o_ready) k++;
        step();
        if (c == 5) begin
          chk("bp_accepted", 64'(k), 64'd2);
          chk("bp_ready_low", o_ready, 1'b0);
        end
      end
    end
    i_valid = 1'b0;
    chk("bp_delivered", 64'(got.size()), 64'd5);
    for (int k = 0; k < 5; k++) chk("bp_order", k < got.size() ? got[k] : '0, bp_vec[k]);
    chk("bp_cnt", o_xfer_cnt, 8'd5);

    b_iready = 1'b1;
    chk("b_err_init", b_err, 1'b0);
    for (int j = 0; j < 5; j++) begin
      {b_mux, b_mode, b_mask} = {btbl[j].mux, btbl[j].mode, btbl[j].mask};
      b_valid = 1'b1;
      step();
      chk("b_valid", b_ovalid, 1'b1);
      chk("b_dist", b_dist, btbl[j].exp_d);
      chk("b_err", b_err, btbl[j].exp_err);
    end
    b_valid = 1'b0;
    step();
    chk("b_cnt_wrap", b_cnt, 2'd1);
    chk("b_err_hold", b_err, 1'b1);

    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data_bus = 32'hDEADBEEF;
    i_mux_bus = 8'h1B;
    i_mode = 2'd0;
    i_pe_mask = 4'hF;
    step();
    i_data_bus = 32'hCAFEF00D;
    step();
    chk("two_ready", o_ready, 1'b0);
    chk("two_valid", o_valid, 1'b1);
    rst = 1'b0;
    i_valid = 1'b0;
    step();
    chk("mid_rst_valid", o_valid, 1'b0);
    chk("mid_rst_dist", o_dist_bus, 32'h0);
    chk("b_err_cleared", b_err, 1'b0);
    rst = 1'b1;
    i_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("mid_rst_gone", o_valid, 1'b0);
    end

    for (int c = 0; c < 400; c++) begin
      i_valid = $urandom_range(0, 3) != 0;
      i_ready = $urandom_range(0, 3) != 0;
      i_data_bus = $urandom;
      i_mux_bus = 8'($urandom);
      i_mode = 2'($urandom);
      i_pe_mask = 4'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
